// File: rtl/modmul_arbiter.sv
// modmul_arbiter: shares one fully pipelined 12-bit modular multiplier (q = 3329)
// between two requesters. One request is issued per cycle. Operands are registered
// into the multiplier, and an {owner, tag} slot follows each product down a shift
// register that lines up with mm_c. Each product is returned to the port that issued it.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   cfg_fix_prio              1: port 0 wins ties; 0: round-robin
//   reqN_valid/ready/a/b/tag  request port N (ready = granted this cycle)
//   rspN_valid/c/tag          result port N, one-cycle pulse, no backpressure
//   mm_a, mm_b, mm_c          registered operands to, and result from, the multiplier
//   busy                      a slot is in flight or a request is accepted this cycle
//   err_range                 sticky: an accepted operand was >= Q
module modmul_arbiter #(
    parameter int unsigned MM_LAT = 4,
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned Q      = 3329
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_fix_prio,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [11:0]      req0_a,
    input  logic [11:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [11:0]      req1_a,
    input  logic [11:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp0_valid,
    output logic [11:0]      rsp0_c,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp1_valid,
    output logic [11:0]      rsp1_c,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic [11:0]      mm_a,
    output logic [11:0]      mm_b,
    input  logic [11:0]      mm_c,
    output logic             busy,
    output logic             err_range
);

    // Stage 0 is loaded together with mm_a/mm_b. MM_LAT further stages follow it,
    // so the last stage is valid in the same cycle as the matching mm_c.
    localparam int unsigned NumStg = MM_LAT + 1;
    localparam logic [11:0] QVal   = 12'(Q);

    logic [NumStg-1:0] vld_q, vld_d;
    logic [NumStg-1:0] own_q, own_d;
    logic [TAG_W-1:0]  tag_q [NumStg];
    logic [TAG_W-1:0]  tag_d [NumStg];
    logic [11:0]       mm_a_q, mm_a_d, mm_b_q, mm_b_d;
    logic              last_gnt_q, last_gnt_d;
    logic              err_q, err_d;

    logic              gnt0, gnt1, accept;
    logic [11:0]       sel_a, sel_b;
    logic [TAG_W-1:0]  sel_tag;

    // last_gnt_q = 1 means port 1 was granted last, so port 0 wins the next tie.
    always_comb begin
        gnt0    = !rst && req0_valid && (!req1_valid || cfg_fix_prio || last_gnt_q);
        gnt1    = !rst && req1_valid && !gnt0;
        accept  = gnt0 || gnt1;
        sel_a   = gnt1 ? req1_a   : req0_a;
        sel_b   = gnt1 ? req1_b   : req0_b;
        sel_tag = gnt1 ? req1_tag : req0_tag;
    end

    always_comb begin
        mm_a_d     = accept ? sel_a : 12'd0;
        mm_b_d     = accept ? sel_b : 12'd0;
        last_gnt_d = accept ? gnt1 : last_gnt_q;
        err_d      = err_q || (accept && (sel_a >= QVal || sel_b >= QVal));
        vld_d      = {vld_q[NumStg-2:0], accept};
        own_d      = {own_q[NumStg-2:0], gnt1};
        tag_d[0]   = sel_tag;
        for (int i = 1; i < NumStg; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            own_q      <= '0;
            mm_a_q     <= 12'd0;
            mm_b_q     <= 12'd0;
            last_gnt_q <= 1'b1;
            err_q      <= 1'b0;
            for (int i = 0; i < NumStg; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q      <= vld_d;
            own_q      <= own_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
            last_gnt_q <= last_gnt_d;
            err_q      <= err_d;
            for (int i = 0; i < NumStg; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    always_comb begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        rsp0_valid = !rst && vld_q[NumStg-1] && !own_q[NumStg-1];
        rsp1_valid = !rst && vld_q[NumStg-1] && own_q[NumStg-1];
        rsp0_c     = mm_c;
        rsp1_c     = mm_c;
        rsp0_tag   = tag_q[NumStg-1];
        rsp1_tag   = tag_q[NumStg-1];
        mm_a       = mm_a_q;
        mm_b       = mm_b_q;
        busy       = !rst && ((|vld_q) || accept);
        err_range  = err_q;
    end

endmodule

// File: tb/tb_modmul_arbiter.sv
module tb_modmul_arbiter;

    localparam int MM_LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_fix_prio = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [11:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [7:0]  req0_tag = '0, req1_tag = '0;
    logic        rsp0_valid, rsp1_valid;
    logic [11:0] rsp0_c, rsp1_c;
    logic [7:0]  rsp0_tag, rsp1_tag;
    logic [11:0] mm_a, mm_b, mm_c;
    logic        busy, err_range;

    modmul_arbiter #(.MM_LAT(MM_LAT), .TAG_W(8), .Q(3329)) dut (
        .clk(clk), .rst(rst), .cfg_fix_prio(cfg_fix_prio),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_tag(req1_tag),
        .rsp0_valid(rsp0_valid), .rsp0_c(rsp0_c), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_c(rsp1_c), .rsp1_tag(rsp1_tag),
        .mm_a(mm_a), .mm_b(mm_b), .mm_c(mm_c), .busy(busy), .err_range(err_range)
    );

    always #5 clk = ~clk;

    // Multiplier model: MM_LAT register stages computing a*b mod 3329.
    logic [11:0] mp [MM_LAT];
    always @(posedge clk) begin
        mp[0] <= 12'((32'(mm_a) * 32'(mm_b)) % 3329);
        for (int i = 1; i < MM_LAT; i++) mp[i] <= mp[i-1];
    end
    assign mm_c = mp[MM_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int c;
        int tag;
        int due;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    int   last_gnt = 1;

    // Monitor: compares every presented result against the head of its port's queue.
    exp_t m0, m1;
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp0_valid) begin
                if (q0.size() == 0) chk("rsp0_spurious", rsp0_valid, 0);
                else begin
                    m0 = q0.pop_front();
                    chk("rsp0_c", rsp0_c, m0.c);
                    chk("rsp0_tag", rsp0_tag, m0.tag);
                    chk("rsp0_cycle", cyc, m0.due);
                end
            end
            if (rsp1_valid) begin
                if (q1.size() == 0) chk("rsp1_spurious", rsp1_valid, 0);
                else begin
                    m1 = q1.pop_front();
                    chk("rsp1_c", rsp1_c, m1.c);
                    chk("rsp1_tag", rsp1_tag, m1.tag);
                    chk("rsp1_cycle", cyc, m1.due);
                end
            end
        end
    end

    // One cycle of stimulus; called at posedge+1. Checks grant and pushes the expected result.
    task automatic step(input logic v0, input int a0, input int b0, input int t0, input int c0,
                        input logic v1, input int a1, input int b1, input int t1, input int c1);
        int   g;
        exp_t e;
        req0_valid = v0; req0_a = 12'(a0); req0_b = 12'(b0); req0_tag = 8'(t0);
        req1_valid = v1; req1_a = 12'(a1); req1_b = 12'(b1); req1_tag = 8'(t1);
        @(negedge clk);
        g = -1;
        if (v0 && v1) g = (cfg_fix_prio || last_gnt == 1) ? 0 : 1;
        else if (v0) g = 0;
        else if (v1) g = 1;
        chk("ready0", req0_ready, int'(g == 0));
        chk("ready1", req1_ready, int'(g == 1));
        if (g >= 0) begin
            chk("busy_on_accept", busy, 1);
            e.due = cyc + 1 + MM_LAT;
            if (g == 0) begin e.c = c0; e.tag = t0; q0.push_back(e); end
            else        begin e.c = c1; e.tag = t1; q1.push_back(e); end
            last_gnt = g;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++) idle(1);
        chk("drain_outstanding", q0.size() + q1.size(), 0);
        idle(2);
    endtask

    // One reset cycle with both requests pending; nothing may be granted or returned.
    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        q0.delete(); q1.delete();
        last_gnt = 1;
        @(negedge clk);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_err", err_range, 0);
        chk("post_rst_mm_a", mm_a, 0);
        chk("post_rst_mm_b", mm_b, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // 1. Single request on port 0: 17*17 = 289.
        step(1, 17, 17, 8'h11, 289, 0, 0, 0, 0, 0);
        drain();

        // 2. Round-robin ties right after reset: grants 0,1,0,1.
        do_reset();
        step(1, 2, 3, 8'h20, 6, 1, 5, 7, 8'h30, 35);
        step(1, 100, 100, 8'h21, 13, 1, 5, 7, 8'h30, 35);
        step(1, 100, 100, 8'h21, 13, 1, 1000, 4, 8'h31, 671);
        step(1, 9, 9, 8'h22, 81, 1, 1000, 4, 8'h31, 671);
        drain();

        // 3. Fixed priority: port 0 wins three ties, then port 1 alone.
        cfg_fix_prio = 1'b1;
        step(1, 12, 12, 8'h40, 144, 1, 7, 8, 8'h50, 56);
        step(1, 12, 12, 8'h41, 144, 1, 7, 8, 8'h50, 56);
        step(1, 12, 12, 8'h42, 144, 1, 7, 8, 8'h50, 56);
        step(0, 0, 0, 0, 0, 1, 7, 8, 8'h50, 56);
        cfg_fix_prio = 1'b0;
        drain();

        // 4. Boundary values and range error.
        step(1, 3328, 3328, 8'h60, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 3000, 3000, 8'h61, 1713);
        @(negedge clk);
        chk("err_before_bad", err_range, 0);
        @(posedge clk); #1;
        step(1, 3329, 5, 8'h62, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("err_after_bad", err_range, 1);
        @(posedge clk); #1;
        drain();
        chk("err_sticky", err_range, 1);

        // 5. Reset while three products are in flight; they must be dropped.
        step(1, 11, 11, 8'h70, 121, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 12, 13, 8'h71, 156);
        step(1, 14, 15, 8'h72, 210, 0, 0, 0, 0, 0);
        idle(1);
        do_reset();
        idle(MM_LAT + 3);
        step(0, 0, 0, 0, 0, 1, 20, 30, 8'h73, 600);
        drain();

        // 6. Short random run in both priority modes.
        for (int i = 0; i < 400; i++) begin
            int a0, b0, a1, b1;
            cfg_fix_prio = (i >= 200);
            a0 = $urandom_range(3328); b0 = $urandom_range(3328);
            a1 = $urandom_range(3328); b1 = $urandom_range(3328);
            step(1'($urandom_range(1)), a0, b0, $urandom_range(255), (a0 * b0) % 3329,
                 1'($urandom_range(1)), a1, b1, $urandom_range(255), (a1 * b1) % 3329);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
